i2c_bus_arbiter: RTL
====================

Name: i2c_bus_arbiter

Overview:
- Shares the single I2C_Controller engine between NREQ independent requesters, e.g. the HDMI transmitter config sequencer, an audio codec config sequencer and a CPU register port.
- Grants the engine round-robin, drives one 24-bit {slave, sub, data} transfer per grant and watches the controller's END/ACK.
- Retries NACKed transfers, aborts hung transfers on timeout, and returns a per-requester done pulse with an error flag.
- Sits between the config sequencers and I2C_Controller; runs on iCLK; the controller's slow work clock is derived from iCLK.

Parameters:
- NREQ, 2, number of requesters (1..8).
- MAX_RETRY, 3, extra attempts after a NACK before reporting error.
- GAP_CYCLES, 5000, iCLK idle cycles between a NACK and the retry.
- TIMEOUT, 200000, iCLK cycles allowed in each wait state before abort.

Ports:
- iCLK, in, 1: system clock.
- iRST_N, in, 1: asynchronous active-low reset.
- req, in, NREQ: per-requester transfer request; level signal.
- req_data, in, 24*NREQ: slice i = {slave_addr, sub_addr, data} for requester i.
- gnt, out, NREQ: one-hot; high for the whole service of the granted requester.
- done, out, NREQ: one-cycle pulse to the served requester at completion.
- err, out, 1: valid only with done; 1 means NACK after all retries, or timeout.
- busy, out, 1: high whenever the FSM is not in IDLE.
- i2c_data, out, 24: to controller I2C_DATA.
- i2c_go, out, 1: to controller GO.
- i2c_end, in, 1: from controller END; idle high, low while a transfer runs.
- i2c_ack, in, 1: from controller ACK; 1 means the slave NACKed.

Behaviour:
- Reset values: gnt=0, done=0, err=0, busy=0, i2c_go=0, i2c_data=0, rr pointer=NREQ-1, retry count=0, timer=0, state IDLE.
- Reset mid-transfer drops i2c_go immediately. No done is issued for the aborted transfer.
- Inputs i2c_end and i2c_ack pass through a 2-flop synchroniser before use.

FSM states and transitions:
- IDLE: if any req is set, pick the winner round-robin. Search starts at (ptr+1) mod NREQ, so the lowest index wins at first use after reset. Then set gnt, latch the winner's req_data into i2c_data, clear the retry count, go to LAUNCH.
- LAUNCH: i2c_go=1, clear timer, go to WAIT_BUSY.
- WAIT_BUSY: wait for synced END=0.
  - On END=0, go to WAIT_END.
  - On timer==TIMEOUT, go to FAIL.
- WAIT_END: wait for synced END=1.
  - On END=1, drop i2c_go, sample ack, go to CHECK.
  - On timer==TIMEOUT, go to FAIL.
  - The timer restarts on entry to WAIT_END.
- CHECK:
  - ack=0: go to FINISH with err=0.
  - ack=1 and retries<MAX_RETRY: increment retries, go to GAP.
  - Otherwise: go to FINISH with err=1.
- GAP: count GAP_CYCLES with i2c_go=0, then go to LAUNCH using the same latched data.
- FAIL: drop i2c_go, err=1, go to FINISH. No retry after a timeout.
- FINISH: pulse done[winner] for 1 cycle, set ptr=winner, clear gnt, go to IDLE. The next grant is no earlier than the cycle after FINISH.

Handshake rules:
- A requester holds req high until done, then deasserts.
- If req is still high the cycle after done, it is treated as a new request. It still loses to any other pending requester because the pointer has advanced.
- req dropping while granted is ignored: the transfer completes and done is still pulsed.
- req_data is latched at grant; later changes have no effect until the next grant.
- i2c_go is only high in LAUNCH, WAIT_BUSY and WAIT_END. It falls within 1 cycle of END returning high, so the controller never sees a back-to-back GO without a low gap.
- err is held until the next done. It is ignored when done=0.
- Timer width is clog2(TIMEOUT+1). The retry counter saturates at MAX_RETRY.

Test Plan:
- Single request: req[0]=1, data 0x729803, controller model ACKs. Required: i2c_data=0x729803, go held until END rises; done[0] 1 cycle, err=0; exactly 1 GO.
- Simultaneous requests: req=2'b11 from reset. Required: req0 served first, then req1. Then re-assert both: req1 is not served first; order alternates 0,1,0,1 over 4 transfers.
- NACK retry: model NACKs twice then ACKs, MAX_RETRY=3. Required: 3 GO assertions, each after a ≥GAP_CYCLES gap; done with err=0.
- Persistent NACK: model always NACKs. Required: 4 GO assertions (MAX_RETRY+1), then done with err=1; gnt clears.
- Timeout: END never falls after GO. Required: at TIMEOUT cycles go drops; done with err=1; no retry.
- Reset mid-transfer: assert iRST_N=0 during WAIT_END. Required: go, gnt, busy are 0 immediately; no done; after release with req still high, the transfer restarts from IDLE.

Source files
------------

// File: rtl/i2c_bus_arbiter_if.sv
// Requester-side and controller-side signals of the I2C engine arbiter.
// The master modport is the arbiter; slave is the requesters plus the I2C_Controller.
interface i2c_bus_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]      req;
    logic [24*NREQ-1:0]   req_data;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      done;
    logic                 err;
    logic                 busy;
    logic [23:0]          i2c_data;
    logic                 i2c_go;
    logic                 i2c_end;
    logic                 i2c_ack;

    modport master (
        input  req, req_data, i2c_end, i2c_ack,
        output gnt, done, err, busy, i2c_data, i2c_go
    );

    modport slave (
        output req, req_data, i2c_end, i2c_ack,
        input  gnt, done, err, busy, i2c_data, i2c_go
    );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter that shares one I2C_Controller between NREQ requesters.
// It issues one 24-bit transfer per grant, retries NACKs and aborts hung transfers.
module i2c_bus_arbiter #(
    parameter int NREQ       = 2,
    parameter int MAX_RETRY  = 3,
    parameter int GAP_CYCLES = 5000,
    parameter int TIMEOUT    = 200000
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    i2c_bus_arbiter_if.master  bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {
        IDLE, LAUNCH, WAIT_BUSY, WAIT_END, CHECK, GAP, FAIL, FINISH
    } state_t;

    state_t           state_q;
    logic [NREQ-1:0]  gnt_q;
    logic [NREQ-1:0]  done_q;
    logic             err_q;
    logic             go_q;
    logic [23:0]      data_q;
    logic [IW-1:0]    ptr_q;
    logic [IW-1:0]    win_q;
    logic [RW-1:0]    retry_q;
    logic [TW-1:0]    timer_q;
    logic [GW-1:0]    gap_q;
    logic             ack_q;
    logic             end_s1_q, end_s2_q;
    logic             ack_s1_q, ack_s2_q;

    logic [IW-1:0]    win_d;
    logic             any_d;
    logic [NREQ-1:0]  win_oh_d;

    // Search starts just after the last served requester so nobody can starve.
    always_comb begin
        win_d    = '0;
        any_d    = 1'b0;
        win_oh_d = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!any_d && bus.req[(int'(ptr_q) + k) % NREQ]) begin
                any_d = 1'b1;
                win_d = IW'((int'(ptr_q) + k) % NREQ);
            end
        end
        win_oh_d[win_d] = 1'b1;
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
            go_q     <= 1'b0;
            data_q   <= '0;
            ptr_q    <= IW'(NREQ - 1);
            win_q    <= '0;
            retry_q  <= '0;
            timer_q  <= '0;
            gap_q    <= '0;
            ack_q    <= 1'b0;
            end_s1_q <= 1'b1;
            end_s2_q <= 1'b1;
            ack_s1_q <= 1'b0;
            ack_s2_q <= 1'b0;
        end else begin
            end_s1_q <= bus.i2c_end;
            end_s2_q <= end_s1_q;
            ack_s1_q <= bus.i2c_ack;
            ack_s2_q <= ack_s1_q;
            done_q   <= '0;
            case (state_q)
                IDLE: begin
                    if (any_d) begin
                        gnt_q   <= win_oh_d;
                        win_q   <= win_d;
                        data_q  <= bus.req_data[int'(win_d)*24 +: 24];
                        retry_q <= '0;
                        go_q    <= 1'b1;
                        state_q <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    timer_q <= '0;
                    state_q <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (!end_s2_q) begin
                        timer_q <= '0;
                        state_q <= WAIT_END;
                    end else if (timer_q == TW'(TIMEOUT)) begin
                        go_q    <= 1'b0;
                        state_q <= FAIL;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                WAIT_END: begin
                    if (end_s2_q) begin
                        go_q    <= 1'b0;
                        ack_q   <= ack_s2_q;
                        state_q <= CHECK;
                    end else if (timer_q == TW'(TIMEOUT)) begin
                        go_q    <= 1'b0;
                        state_q <= FAIL;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                CHECK: begin
                    if (!ack_q) begin
                        err_q   <= 1'b0;
                        done_q  <= gnt_q;
                        state_q <= FINISH;
                    end else if (retry_q < RW'(MAX_RETRY)) begin
                        retry_q <= retry_q + RW'(1);
                        gap_q   <= '0;
                        state_q <= GAP;
                    end else begin
                        err_q   <= 1'b1;
                        done_q  <= gnt_q;
                        state_q <= FINISH;
                    end
                end
                // CHECK already kept GO low for one cycle, so the gap is at least GAP_CYCLES.
                GAP: begin
                    if (gap_q == GW'(GAP_CYCLES - 1)) begin
                        go_q    <= 1'b1;
                        state_q <= LAUNCH;
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end
                FAIL: begin
                    go_q    <= 1'b0;
                    err_q   <= 1'b1;
                    done_q  <= gnt_q;
                    state_q <= FINISH;
                end
                FINISH: begin
                    gnt_q   <= '0;
                    ptr_q   <= win_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.i2c_data = data_q;
    assign bus.i2c_go   = go_q;
endmodule
